// File: rtl/dpram_be_clr_if.sv
// Bus bundle for dpram_be_clr: write/clear controls and status on the write side,
// read request and response on the read side.
interface dpram_be_clr_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] data;
    logic [NB-1:0]         byte_en;
    logic                  par_inject;
    logic                  clear_req;
    logic                  clear_busy;
    logic                  wr_ready;
    logic [7:0]            drop_cnt;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  parity_err;

    modport master (
        output we, write_addr, data, byte_en, par_inject, clear_req, read_en, read_addr,
        input  clear_busy, wr_ready, drop_cnt, q, q_valid, parity_err
    );

    modport slave (
        input  we, write_addr, data, byte_en, par_inject, clear_req, read_en, read_addr,
        output clear_busy, wr_ready, drop_cnt, q, q_valid, parity_err
    );
endinterface

// File: rtl/dpram_be_clr.sv
// Simple dual-port RAM with byte enables, clear engine, dropped-write counter and read pipeline.
// Optional per-lane even parity storage/check enabled by defining DPRAM_PARITY_EN.
module dpram_be_clr #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          BYTE_WIDTH = 8,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter int unsigned          OUT_REG    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic               write_clock,
    input  logic               rst,
    input  logic               read_clock,
    dpram_be_clr_if.slave      bus
);
    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;
    logic                  r_clear_busy;
    logic                  r_wr_ready;
    logic [7:0]            r_drop_cnt;

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic [NB-1:0]         w_lane_en;
    logic                  w_par_flip;
    logic                  w_drop;

    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [NB-1:0]         w_rd_lane_err;
    logic                  w_rd_perr;

    // Write-side state register
    always_ff @(posedge write_clock) begin
        r_state      <= w_state_nxt;
        r_clr_addr   <= w_clr_addr_nxt;
        r_clear_busy <= (w_state_nxt == S_CLEAR);
        r_wr_ready   <= (w_state_nxt != S_CLEAR);
    end

    // Next-state and RAM write-port steering; reset parks the engine at address 0
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_mem_we       = 1'b0;
        w_mem_addr     = bus.write_addr;
        w_mem_data     = bus.data;
        w_lane_en      = bus.byte_en;
        w_par_flip     = bus.par_inject;
        w_drop         = 1'b0;
        if (rst) begin
            w_state_nxt    = S_CLEAR;
            w_clr_addr_nxt = '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    w_mem_we       = 1'b1;
                    w_mem_addr     = r_clr_addr;
                    w_mem_data     = INIT_VALUE;
                    w_lane_en      = '1;
                    w_par_flip     = 1'b0;
                    w_drop         = bus.we;
                    w_clr_addr_nxt = ADDR_WIDTH'(r_clr_addr + 1'b1);
                    if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_IDLE: begin
                    w_mem_we = bus.we;
                    if (bus.clear_req) begin
                        w_state_nxt    = S_CLEAR;
                        w_clr_addr_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            endcase
        end
    end

    // Saturating count of writes refused while the clear engine owns the port
    always_ff @(posedge write_clock) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.clear_busy = r_clear_busy;
    assign bus.wr_ready   = r_wr_ready;
    assign bus.drop_cnt   = r_drop_cnt;

    // One storage array per lane so partial writes never touch neighbouring lanes
    for (genvar g = 0; g < NB; g++) begin : g_lane
        logic [BYTE_WIDTH-1:0] r_mem [DEPTH];

        always_ff @(posedge write_clock) begin
            if (w_mem_we && w_lane_en[g]) begin
                r_mem[w_mem_addr] <= w_mem_data[g*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end

        assign w_rd_word[g*BYTE_WIDTH +: BYTE_WIDTH] = r_mem[bus.read_addr];

`ifdef DPRAM_PARITY_EN
        logic r_par [DEPTH];

        always_ff @(posedge write_clock) begin
            if (w_mem_we && w_lane_en[g]) begin
                r_par[w_mem_addr] <= (^w_mem_data[g*BYTE_WIDTH +: BYTE_WIDTH]) ^ w_par_flip;
            end
        end

        assign w_rd_lane_err[g] = (^r_mem[bus.read_addr]) ^ r_par[bus.read_addr];
`else
        assign w_rd_lane_err[g] = 1'b0;
`endif
    end

`ifndef DPRAM_PARITY_EN
    logic w_unused_par;
    assign w_unused_par = w_par_flip ^ (|w_rd_lane_err);
    assign w_rd_perr    = 1'b0;
`else
    assign w_rd_perr    = |w_rd_lane_err;
`endif

    // Reset crosses into the read domain through a two-flop synchroniser
    logic r_rd_rst_meta;
    logic r_rd_rst;

    always_ff @(posedge read_clock) begin
        r_rd_rst_meta <= rst;
        r_rd_rst      <= r_rd_rst_meta;
    end

    logic [DATA_WIDTH-1:0] r_s1_word;
    logic                  r_s1_vld;
    logic                  r_s1_perr;

    // First read stage: RAM word captured only on read_en, so it holds between reads
    always_ff @(posedge read_clock) begin
        if (r_rd_rst) begin
            r_s1_word <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_perr <= 1'b0;
        end else begin
            r_s1_vld  <= bus.read_en;
            r_s1_perr <= bus.read_en & w_rd_perr;
            if (bus.read_en) begin
                r_s1_word <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_s2_word;
        logic                  r_s2_vld;
        logic                  r_s2_perr;

        always_ff @(posedge read_clock) begin
            if (r_rd_rst) begin
                r_s2_word <= '0;
                r_s2_vld  <= 1'b0;
                r_s2_perr <= 1'b0;
            end else begin
                r_s2_vld  <= r_s1_vld;
                r_s2_perr <= r_s1_perr;
                if (r_s1_vld) begin
                    r_s2_word <= r_s1_word;
                end
            end
        end

        assign bus.q          = r_s2_word;
        assign bus.q_valid    = r_s2_vld;
        assign bus.parity_err = r_s2_perr;
    end else begin : g_no_out_reg
        assign bus.q          = r_s1_word;
        assign bus.q_valid    = r_s1_vld;
        assign bus.parity_err = r_s1_perr;
    end

endmodule
